// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master side requests an operation; the slave side (the subtractor)
// reports progress and the registered result.
interface serial_sub_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, borrow
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b - bin over WIDTH bits, LSB first,
// one bit per clock through a single full-subtract cell and a borrow flop.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | waiting for start; diff/borrow hold the last completed result
//  RUN   | one operand bit per edge; cnt counts processed bits
//  DONE  | done pulse for one cycle; returns to IDLE unconditionally
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    serial_sub_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             d_bit;
    logic             br_next;

    // Shared full-subtract cell operating on the current LSBs.
    always_comb begin
        d_bit   = ra_q[0] ^ rb_q[0] ^ br_q;
        br_next = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);
    end

    // Next-state logic: operand capture, serial shifting and result commit.
    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    br_d    = bus.bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                br_d  = br_next;
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                res_d = {d_bit, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                // Only the completed word is ever exposed on diff/borrow.
                if (cnt_q == LAST) begin
                    diff_d   = {d_bit, res_q[WIDTH-1:1]};
                    borrow_d = br_next;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    // Status decodes straight from state; results from their registers.
    always_comb begin
        bus.busy   = (state_q == RUN);
        bus.done   = (state_q == DONE);
        bus.diff   = diff_q;
        bus.borrow = borrow_q;
    end
endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub at WIDTH=4: vector table, multi-cycle
// corner sequences and an exhaustive operand sweep.
module tb_serial_sub;
    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] exp_diff;
        logic         exp_borrow;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_sub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issues one operation and waits (bounded) for done. Returns at the
    // negedge inside the DONE cycle. Operand inputs are scrambled during RUN.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          output logic [W-1:0] d, output logic bo, output int lat,
                          output int busy_cnt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.bin   = ~bin;
        lat      = -1;
        busy_cnt = 0;
        for (int n = 0; n < 4 * W; n++) begin
            if (bus.done) begin
                lat = n;
                break;
            end
            if (bus.busy) busy_cnt++;
            @(negedge clk);
        end
        d  = bus.diff;
        bo = bus.borrow;
    endtask

    vec_t         vecs[10];
    logic [W-1:0] d;
    logic         bo;
    int           lat;
    int           bcnt;
    int           pulses;
    logic [W:0]   full;

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;

        vecs[0] = '{4'd5,  4'd3,  1'b0, 4'd2,  1'b0};
        vecs[1] = '{4'd3,  4'd5,  1'b0, 4'd14, 1'b1};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
        vecs[3] = '{4'd9,  4'd9,  1'b0, 4'd0,  1'b0};
        vecs[4] = '{4'd12, 4'd4,  1'b0, 4'd8,  1'b0};
        vecs[5] = '{4'd7,  4'd2,  1'b0, 4'd5,  1'b0};
        vecs[6] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
        vecs[7] = '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1};
        vecs[8] = '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0};
        vecs[9] = '{4'd10, 4'd5,  1'b1, 4'd4,  1'b0};

        repeat (2) @(negedge clk);
        chk("reset_busy",   32'(bus.busy),   32'd0);
        chk("reset_done",   32'(bus.done),   32'd0);
        chk("reset_diff",   32'(bus.diff),   32'd0);
        chk("reset_borrow", 32'(bus.borrow), 32'd0);
        rst = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, lat, bcnt);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(W));
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(W));
            chk($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].exp_diff));
            chk($sformatf("vec%0d_borrow", i), 32'(bo), 32'(vecs[i].exp_borrow));
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
            chk($sformatf("vec%0d_idle_busy", i), 32'(bus.busy), 32'd0);
        end

        // Start pulsed again during RUN and during DONE: both ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd12; bus.b = 4'd4; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd1; bus.b = 4'd2; bus.bin = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            if (bus.done) begin
                pulses++;
                chk("ignore_run_diff",   32'(bus.diff),   32'd8);
                chk("ignore_run_borrow", 32'(bus.borrow), 32'd0);
                bus.start = 1'b1; bus.a = 4'd1; bus.b = 4'd2; bus.bin = 1'b0;
                @(negedge clk);
                bus.start = 1'b0;
                chk("ignore_done_busy", 32'(bus.busy), 32'd0);
            end
            @(negedge clk);
        end
        chk("ignore_pulses", 32'(pulses), 32'd1);
        chk("ignore_done_nostart", 32'(bus.busy), 32'd0);
        chk("ignore_hold_diff", 32'(bus.diff), 32'd8);

        // Reset asserted in the second RUN cycle aborts the operation.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd7; bus.b = 4'd2; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",   32'(bus.busy),   32'd0);
        chk("abort_done",   32'(bus.done),   32'd0);
        chk("abort_diff",   32'(bus.diff),   32'd0);
        chk("abort_borrow", 32'(bus.borrow), 32'd0);
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            if (bus.done) pulses++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(pulses), 32'd0);
        run_op(4'd7, 4'd2, 1'b0, d, bo, lat, bcnt);
        chk("abort_restart_latency", 32'(lat), 32'(W));
        chk("abort_restart_diff",    32'(d),   32'd5);
        chk("abort_restart_borrow",  32'(bo),  32'd0);

        // Result holds through an idle stretch.
        run_op(4'd5, 4'd3, 1'b0, d, bo, lat, bcnt);
        chk("hold_first_diff", 32'(d), 32'd2);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("hold_diff",   32'(bus.diff),   32'd2);
            chk("hold_borrow", 32'(bus.borrow), 32'd0);
            chk("hold_done",   32'(bus.done),   32'd0);
        end

        // Exhaustive sweep against an arithmetic model.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    full = {1'b0, 4'(ai)} - {1'b0, 4'(bi)} - 5'(ci);
                    run_op(4'(ai), 4'(bi), 1'(ci), d, bo, lat, bcnt);
                    chk($sformatf("sweep_%0d_%0d_%0d_lat", ai, bi, ci), 32'(lat), 32'(W));
                    chk($sformatf("sweep_%0d_%0d_%0d_diff", ai, bi, ci), 32'(d), 32'(full[W-1:0]));
                    chk($sformatf("sweep_%0d_%0d_%0d_borrow", ai, bi, ci), 32'(bo), 32'(full[W]));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
